ones_zeros_recognizer: RTL and testbench
========================================

ONES_ZEROS_RECOGNIZER -- requirements
Module: ones_zeros_recognizer

Interface
REQ-001 SHALL have parameter COUNT_W, default 8, width of the match_count frame counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port din  input  1  serial data bit.
REQ-005 SHALL have port din_valid  input  1  din accepted on a rising edge when high.
REQ-006 SHALL have port frame_start  input  1  clears recognition state at the start of a frame.
REQ-007 SHALL have port frame_end  input  1  marks the accepted bit as the last of its frame.
REQ-008 SHALL have port state  output  3  present state {ones[1:0], zpar}.
REQ-009 SHALL have ports j_out and k_out  output  3 each  JK excitation per state bit, driving the downstream jkff state bank.
REQ-010 SHALL have port match  output  1  registered: at least two 1s and an odd number of 0s in the current frame.
REQ-011 SHALL have port frame_match  output  1  one-cycle pulse giving the frame verdict.
REQ-012 SHALL have port match_count  output  COUNT_W  number of matching frames, saturating.

Function
REQ-013 SHALL implement six states: S0E=000, S0O=001, S1E=010, S1O=011, S2E=100, S2O=101; codes 110/111 SHALL go to S0E on the next edge.
REQ-014 SHALL, on an accepted bit with din=1, advance ones 0->1->2, saturating at 2; zpar unchanged.
REQ-015 SHALL, on an accepted bit with din=0, toggle zpar; ones unchanged.
REQ-016 SHALL hold state when din_valid=0 and frame_start=0.
REQ-017 SHALL, when frame_start=1 and din_valid=0, load S0E.
REQ-018 SHALL, when frame_start=1 and din_valid=1, apply din to S0E, so the bit is the first of the new frame.
REQ-019 SHALL register match = (state==S2O), with one-cycle latency from the accepting edge.
REQ-020 SHALL compute j_out/k_out combinationally per bit from present and next state: 0->1 gives j=1,k=0; 1->0 gives j=0,k=1; unchanged gives j=0,k=0; j=k=1 never driven.
REQ-021 SHALL, on an edge with din_valid=1 and frame_end=1, pulse frame_match high next cycle if and only if the resulting state is S2O; frame_end without din_valid SHALL be ignored.
REQ-022 SHALL treat frame_start=frame_end=din_valid=1 as a complete one-bit frame; verdict per REQ-021.
REQ-023 SHALL clear the state to S0E on the edge after a frame_end acceptance unless frame_start is asserted with valid.
REQ-024 SHALL increment match_count on each frame_match pulse and saturate at 2^COUNT_W-1 without wrap.

Reset
REQ-025 SHALL, while rst=0, asynchronously force state=S0E, match=0, frame_match=0, match_count=0, independent of clk.
REQ-026 SHALL let j_out/k_out follow the reset state; reset mid-frame SHALL discard the partial frame with no frame_match.
REQ-027 SHALL accept the first bit on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with macro ONES_ZEROS_MATCH_COUNT_EN defined, include the match_count counter per REQ-024.
REQ-029 SHALL, without ONES_ZEROS_MATCH_COUNT_EN, drive match_count constant 0 and synthesize no counter; all other behaviour unchanged.

Verification
REQ-030 SHALL cover: frame bits 1,0,1 (frame_end on the last) -> state S2O, match=1, frame_match pulse, match_count=1.
REQ-031 SHALL cover: frame bits 1,1,0,0 -> state S2E, match=0, no frame_match pulse, match_count unchanged.
REQ-032 SHALL cover: a jkff bank driven by j_out/k_out over 200 random valid bits -> bank equals state on every cycle.
REQ-033 SHALL cover: rst pulled low between clk edges mid-frame after bits 1,1 -> state=S0E immediately, match=0, no pulse.
REQ-034 SHALL cover: COUNT_W=2 with 5 matching frames -> match_count stops at 3; with the macro undefined -> match_count stays 0.
REQ-035 SHALL cover: din_valid gaps, and frame_start+frame_end+din_valid with din=0 -> state S0O, match=0, no frame_match.

Source files
------------

// File: rtl/ones_zeros_recognizer_if.sv
// Serial bit stream and recognizer result bundle between a bit source and
// the ones/zeros recognizer.
interface ones_zeros_recognizer_if #(
  parameter int COUNT_W = 8
);
  logic               din;
  logic               din_valid;
  logic               frame_start;
  logic               frame_end;
  logic [2:0]         state;
  logic [2:0]         j_out;
  logic [2:0]         k_out;
  logic               match;
  logic               frame_match;
  logic [COUNT_W-1:0] match_count;

  modport master (
    output din, din_valid, frame_start, frame_end,
    input  state, j_out, k_out, match, frame_match, match_count
  );

  modport slave (
    input  din, din_valid, frame_start, frame_end,
    output state, j_out, k_out, match, frame_match, match_count
  );
endinterface

// File: rtl/ones_zeros_recognizer.sv
// Frame-based recognizer: at least two 1s and an odd number of 0s; JK excitation
// for an external flop bank. Define ONES_ZEROS_MATCH_COUNT_EN to add the match counter.
module ones_zeros_recognizer #(
  parameter int COUNT_W = 8
) (
  input logic                     clk,
  input logic                     rst,
  ones_zeros_recognizer_if.slave  bus
);

  typedef enum logic [2:0] {
    S0E = 3'b000,
    S0O = 3'b001,
    S1E = 3'b010,
    S1O = 3'b011,
    S2E = 3'b100,
    S2O = 3'b101
  } state_e;

  state_e st_q, st_d, base;
  logic   clr_q, clr_d;
  logic   match_q, match_d;
  logic   fm_q, fm_d;
  logic   legal;
  logic [2:0] cur_bits, nxt_bits;

  // state code is {ones[1:0], zpar}; ones saturates at 2
  function automatic state_e apply_bit(input state_e s, input logic b);
    logic [2:0] v;
    v = s;
    if (b) begin
      if (v[2:1] != 2'd2) v[2:1] = v[2:1] + 2'd1;
    end else begin
      v[0] = ~v[0];
    end
    return state_e'(v);
  endfunction

  always_comb begin
    st_d  = st_q;
    base  = st_q;
    clr_d = 1'b0;
    fm_d  = 1'b0;
    legal = (st_q[2:1] != 2'b11);
    // the edge after a frame_end closes the frame unless a new one starts with a bit
    if (!legal || (clr_q && !(bus.frame_start && bus.din_valid))) begin
      st_d = S0E;
    end else begin
      base  = bus.frame_start ? S0E : st_q;
      st_d  = bus.din_valid ? apply_bit(base, bus.din) : base;
      clr_d = bus.din_valid && bus.frame_end;
      fm_d  = clr_d && (st_d == S2O);
    end
    match_d = (st_d == S2O);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= S0E;
      clr_q   <= 1'b0;
      match_q <= 1'b0;
      fm_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      clr_q   <= clr_d;
      match_q <= match_d;
      fm_q    <= fm_d;
    end
  end

  assign cur_bits        = st_q;
  assign nxt_bits        = st_d;
  assign bus.state       = cur_bits;
  assign bus.j_out       = ~cur_bits & nxt_bits;
  assign bus.k_out       = cur_bits & ~nxt_bits;
  assign bus.match       = match_q;
  assign bus.frame_match = fm_q;

`ifdef ONES_ZEROS_MATCH_COUNT_EN
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // counts alongside the pulse so match_count and frame_match update together
  always_comb begin
    cnt_d = cnt_q;
    if (fm_d) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bus.match_count = cnt_q;
`else
  assign bus.match_count = {COUNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ones_zeros_recognizer.sv
// Directed and random bench for ones_zeros_recognizer with a scoreboard model
// and a JK flop bank driven from j_out/k_out.
module tb_ones_zeros_recognizer;
  localparam int CW = 2;
`ifdef ONES_ZEROS_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]    st;
    logic          m;
    logic          fm;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  ones_zeros_recognizer_if #(.COUNT_W(CW)) bus ();

  ones_zeros_recognizer #(.COUNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ones  = 0;
  bit   m_zpar  = 1'b0;
  bit   m_clr   = 1'b0;
  int   m_cnt   = 0;
  logic [2:0] bank;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) bank <= 3'b000;
    else begin
      for (int i = 0; i < 3; i++) begin
        case ({bus.j_out[i], bus.k_out[i]})
          2'b10:   bank[i] <= 1'b1;
          2'b01:   bank[i] <= 1'b0;
          2'b11:   bank[i] <= ~bank[i];
          default: bank[i] <= bank[i];
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ones = 0;
    m_zpar = 1'b0;
    m_clr  = 1'b0;
    m_cnt  = 0;
  endtask

  // one clock of stimulus: model predicts, DUT edge, scoreboard compares
  task automatic step(input logic d, input logic v, input logic fs, input logic fe);
    exp_t e;
    bit   fm;
    bus.din = d; bus.din_valid = v; bus.frame_start = fs; bus.frame_end = fe;
    fm = 1'b0;
    if (m_clr && !(fs && v)) begin
      m_ones = 0; m_zpar = 1'b0; m_clr = 1'b0;
    end else begin
      if (fs) begin m_ones = 0; m_zpar = 1'b0; end
      if (v) begin
        if (d) begin if (m_ones < 2) m_ones++; end
        else m_zpar = !m_zpar;
      end
      fm    = v && fe && (m_ones == 2) && m_zpar;
      m_clr = v && fe;
    end
    if (fm && CNT_EN && (m_cnt < (1 << CW) - 1)) m_cnt++;
    e.st  = 3'(m_ones * 2 + int'(m_zpar));
    e.m   = (m_ones == 2) && m_zpar;
    e.fm  = fm;
    e.cnt = CW'(m_cnt);
    sb.push_back(e);
    #1;
    chk("jk_exclusive", 8'(bus.j_out & bus.k_out), 8'h00);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("state", 8'(bus.state), 8'(e.st));
    chk("match", 8'(bus.match), 8'(e.m));
    chk("frame_match", 8'(bus.frame_match), 8'(e.fm));
    chk("match_count", 8'(bus.match_count), 8'(e.cnt));
    chk("jk_bank", 8'(bank), 8'(bus.state));
  endtask

  initial begin
    int nvalid;
    int guard;
    logic v, fs, fe, d;
    rst = 1'b0;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.frame_start = 1'b0; bus.frame_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 8'(bus.state), 8'h00);
    chk("rst_match", 8'(bus.match), 8'h00);
    chk("rst_fm", 8'(bus.frame_match), 8'h00);
    chk("rst_count", 8'(bus.match_count), 8'h00);
    chk("rst_j", 8'(bus.j_out), 8'h00);
    chk("rst_k", 8'(bus.k_out), 8'h00);
    rst = 1'b1;
    model_reset();

    // frame 1,0,1 -> S2O and a verdict pulse
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("f101_state", 8'(bus.state), 8'h05);
    chk("f101_fm", 8'(bus.frame_match), 8'h01);
    chk("f101_count", 8'(bus.match_count), CNT_EN ? 8'h01 : 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("f101_cleared", 8'(bus.state), 8'h00);

    // frame 1,1,0,0 -> S2E, no pulse
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("f1100_state", 8'(bus.state), 8'h04);
    chk("f1100_fm", 8'(bus.frame_match), 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // valid gaps, ignored frame_end without valid, then one-bit frame din=0
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("onebit_state", 8'(bus.state), 8'h01);
    chk("onebit_fm", 8'(bus.frame_match), 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset between edges mid-frame
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    bus.din_valid = 1'b0; bus.frame_start = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("arst_state", 8'(bus.state), 8'h00);
    chk("arst_match", 8'(bus.match), 8'h00);
    chk("arst_fm", 8'(bus.frame_match), 8'h00);
    chk("arst_count", 8'(bus.match_count), 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    chk("arst_hold_fm", 8'(bus.frame_match), 8'h00);
    #3 rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("first_bit", 8'(bus.state), 8'h02);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // five back-to-back matching frames: counter saturates
    for (int f = 0; f < 5; f++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
    end
    chk("sat_count", 8'(bus.match_count), CNT_EN ? 8'h03 : 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // random stream with JK bank tracking
    nvalid = 0;
    guard  = 0;
    while (nvalid < 200 && guard < 2000) begin
      v  = ($urandom_range(0, 9) < 8);
      fs = ($urandom_range(0, 9) == 0);
      fe = ($urandom_range(0, 7) == 0);
      d  = 1'($urandom_range(0, 1));
      step(d, v, fs, fe);
      if (v) nvalid++;
      guard++;
    end
    chk("random_budget", 8'(nvalid >= 200), 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
